dispatch_batch_sched: RTL and testbench

Batch scheduler for the dispatch stage. Given ISSUE_CNT issue slots grouped into batches of BLOCK_SIZE, it selects which batch drives the BLOCK_SIZE execute blocks, holds it until every valid slot in the batch has issued its end-of-packet, then jumps round-robin to the next batch that has work. Empty batches are skipped instead of being visited in fixed rotation. It sits between the issue slots and the per-block packet splitters, and supplies the batch index and per-block enables they consume.

---
 rtl/dispatch_batch_sched_pkg.sv | 19 +
 rtl/dispatch_batch_sched_if.sv | 34 +++
 rtl/dispatch_rr_pick.sv | 38 +++
 rtl/dispatch_batch_sched.sv | 110 +++++++++++
 tb/tb_dispatch_batch_sched.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_batch_sched_pkg.sv
// Shared definitions for the dispatch batch scheduler: FSM states and the
// batch-geometry helpers used by both the interface and the RTL.
package dispatch_batch_sched_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } sched_state_e;

  // Width of an index that can address n items; never narrower than one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int batch_count(input int issue_cnt, input int block_size);
    return issue_cnt / block_size;
  endfunction

endpackage

// File: rtl/dispatch_batch_sched_if.sv
// Bundle between the issue slots / execute blocks (master) and the batch
// scheduler (slave).
interface dispatch_batch_sched_if #(
  parameter int ISSUE_CNT  = 4,
  parameter int BLOCK_SIZE = 1,
  parameter int PERF_W     = 32
);
  import dispatch_batch_sched_pkg::*;

  localparam int BATCH_COUNT = batch_count(ISSUE_CNT, BLOCK_SIZE);
  localparam int BATCH_W     = log2up(BATCH_COUNT);

  logic [ISSUE_CNT-1:0]  dispatch_valid;
  logic [BLOCK_SIZE-1:0] block_fire_eop;
  logic [BATCH_W-1:0]    batch_idx;
  logic                  batch_valid;
  logic [BLOCK_SIZE-1:0] block_enable;
  logic                  batch_switch;
  logic [PERF_W-1:0]     perf_idle_cycles;
  logic [PERF_W-1:0]     perf_batches;

  modport master (
    output dispatch_valid, block_fire_eop,
    input  batch_idx, batch_valid, block_enable, batch_switch,
           perf_idle_cycles, perf_batches
  );

  modport slave (
    input  dispatch_valid, block_fire_eop,
    output batch_idx, batch_valid, block_enable, batch_switch,
           perf_idle_cycles, perf_batches
  );

endinterface

// File: rtl/dispatch_rr_pick.sv
// Combinational round-robin search: first set bit of valid at or after start,
// wrapping modulo N. Callers pass start+1 to put the current entry last.
module dispatch_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [W-1:0]   cand [N];

  assign doubled = {valid, valid};
  assign rotated = doubled[start +: N];

  for (genvar i = 0; i < N; i++) begin : g_cand
    assign cand[i] = (int'(start) + i >= N) ? W'(int'(start) + i - N)
                                            : W'(int'(start) + i);
  end

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found = 1'b1;
        idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/dispatch_batch_sched.sv
// Batch scheduler: serves one batch of issue slots until every valid slot has
// sent its end-of-packet, then moves round-robin to the next non-empty batch.
module dispatch_batch_sched
  import dispatch_batch_sched_pkg::*;
#(
  parameter int ISSUE_CNT  = 4,
  parameter int BLOCK_SIZE = 1,
  parameter int PERF_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dispatch_batch_sched_if.slave  bus
);

  localparam int BATCH_COUNT = batch_count(ISSUE_CNT, BLOCK_SIZE);
  localparam int BATCH_W     = log2up(BATCH_COUNT);
  localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(BATCH_COUNT - 1);

  if ((ISSUE_CNT % BLOCK_SIZE) != 0) begin : g_bad_cfg
    $error("dispatch_batch_sched: ISSUE_CNT must be a multiple of BLOCK_SIZE");
  end

  sched_state_e          state;
  logic [BATCH_W-1:0]    batch_idx;
  logic [BATCH_W-1:0]    next_idx;
  logic [BATCH_W-1:0]    pick_start;
  logic [BATCH_W-1:0]    pick_idx;
  logic                  pick_found;
  logic [BATCH_COUNT-1:0] pick_valid;
  logic [BLOCK_SIZE-1:0] done_mask;
  logic [BLOCK_SIZE-1:0] cur_valid;
  logic                  complete;
  logic                  batch_switch;
  logic [PERF_W-1:0]     perf_idle_cycles;
  logic [PERF_W-1:0]     perf_batches;
  logic [BLOCK_SIZE-1:0] batch_slots [BATCH_COUNT];

  for (genvar k = 0; k < BATCH_COUNT; k++) begin : g_batch
    logic [BLOCK_SIZE-1:0] eop_excl;
    assign batch_slots[k] = bus.dispatch_valid[k*BLOCK_SIZE +: BLOCK_SIZE];
    // While serving this batch, slots finishing this cycle no longer count as work.
    assign eop_excl = (state == ST_ACTIVE && batch_idx == BATCH_W'(k))
                      ? bus.block_fire_eop : '0;
    assign pick_valid[k] = |(batch_slots[k] & ~eop_excl);
  end

  assign cur_valid  = batch_slots[batch_idx];
  assign complete   = &(~cur_valid | done_mask | bus.block_fire_eop);
  assign next_idx   = (batch_idx == LAST_BATCH) ? '0 : batch_idx + 1'b1;
  assign pick_start = (state == ST_IDLE) ? batch_idx : next_idx;

  dispatch_rr_pick #(
    .N (BATCH_COUNT),
    .W (BATCH_W)
  ) u_pick (
    .valid (pick_valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      batch_idx        <= '0;
      done_mask        <= '0;
      batch_switch     <= 1'b0;
      perf_idle_cycles <= '0;
      perf_batches     <= '0;
    end else begin
      batch_switch <= 1'b0;
      case (state)
        ST_IDLE: begin
          perf_idle_cycles <= perf_idle_cycles + 1'b1;
          if (pick_found) begin
            state     <= ST_ACTIVE;
            batch_idx <= pick_idx;
            done_mask <= '0;
          end
        end
        ST_ACTIVE: begin
          if (complete) begin
            done_mask    <= '0;
            perf_batches <= perf_batches + 1'b1;
            if (pick_found) begin
              batch_idx    <= pick_idx;
              batch_switch <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              batch_idx <= next_idx;
            end
          end else begin
            done_mask <= done_mask | bus.block_fire_eop;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.batch_idx        = batch_idx;
  assign bus.batch_valid      = (state == ST_ACTIVE);
  assign bus.block_enable     = {BLOCK_SIZE{state == ST_ACTIVE}} & ~done_mask;
  assign bus.batch_switch     = batch_switch;
  assign bus.perf_idle_cycles = perf_idle_cycles;
  assign bus.perf_batches     = perf_batches;

endmodule

// File: tb/tb_dispatch_batch_sched.sv
// Bench for dispatch_batch_sched: three geometries (4x1, 4x2, 6x2) with
// directed scenarios plus random traffic against a behavioural model.
module tb_dispatch_batch_sched;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [5:0] dv    [3];
  logic [1:0] eop   [3];
  logic [5:0] fired [3];

  int c_issue [3] = '{4, 4, 6};
  int c_bs    [3] = '{1, 2, 2};

  dispatch_batch_sched_if #(.ISSUE_CNT(4), .BLOCK_SIZE(1), .PERF_W(32)) i41 ();
  dispatch_batch_sched_if #(.ISSUE_CNT(4), .BLOCK_SIZE(2), .PERF_W(32)) i42 ();
  dispatch_batch_sched_if #(.ISSUE_CNT(6), .BLOCK_SIZE(2), .PERF_W(32)) i62 ();

  assign i41.dispatch_valid = dv[0][3:0];
  assign i41.block_fire_eop = eop[0][0:0];
  assign i42.dispatch_valid = dv[1][3:0];
  assign i42.block_fire_eop = eop[1];
  assign i62.dispatch_valid = dv[2];
  assign i62.block_fire_eop = eop[2];

  dispatch_batch_sched #(.ISSUE_CNT(4), .BLOCK_SIZE(1), .PERF_W(32)) d41 (
    .clk(clk), .reset_n(reset_n), .bus(i41));
  dispatch_batch_sched #(.ISSUE_CNT(4), .BLOCK_SIZE(2), .PERF_W(32)) d42 (
    .clk(clk), .reset_n(reset_n), .bus(i42));
  dispatch_batch_sched #(.ISSUE_CNT(6), .BLOCK_SIZE(2), .PERF_W(32)) d62 (
    .clk(clk), .reset_n(reset_n), .bus(i62));

  logic [31:0] o_idx [3], o_en [3], o_pidle [3], o_pbat [3];
  logic        o_valid [3], o_sw [3];

  assign o_idx[0] = 32'(i41.batch_idx);   assign o_en[0] = 32'(i41.block_enable);
  assign o_idx[1] = 32'(i42.batch_idx);   assign o_en[1] = 32'(i42.block_enable);
  assign o_idx[2] = 32'(i62.batch_idx);   assign o_en[2] = 32'(i62.block_enable);
  assign o_valid[0] = i41.batch_valid;    assign o_sw[0] = i41.batch_switch;
  assign o_valid[1] = i42.batch_valid;    assign o_sw[1] = i42.batch_switch;
  assign o_valid[2] = i62.batch_valid;    assign o_sw[2] = i62.batch_switch;
  assign o_pidle[0] = i41.perf_idle_cycles; assign o_pbat[0] = i41.perf_batches;
  assign o_pidle[1] = i42.perf_idle_cycles; assign o_pbat[1] = i42.perf_batches;
  assign o_pidle[2] = i62.perf_idle_cycles; assign o_pbat[2] = i62.perf_batches;

  // Reference model state, one entry per geometry.
  bit          m_active [3];
  int          m_idx    [3];
  int          m_done   [3];
  bit          m_sw     [3];
  int unsigned m_pidle  [3];
  int unsigned m_pbat   [3];

  function automatic logic bit_of(input logic [5:0] v, input int i);
    logic [5:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic bit batch_busy(input int c, input int k, input logic [5:0] v);
    for (int b = 0; b < c_bs[c]; b++)
      if (bit_of(v, k * c_bs[c] + b)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the scheduling rules, applied to the inputs driven this cycle.
  task automatic model_step(input int c);
    int  nb, bs, k;
    bit  found, complete;
    logic [5:0] eslots, v;
    nb = c_issue[c] / c_bs[c];
    bs = c_bs[c];
    m_sw[c] = 1'b0;
    if (!m_active[c]) begin
      m_pidle[c]++;
      found = 1'b0;
      for (int i = 0; i < nb; i++) begin
        k = (m_idx[c] + i) % nb;
        if (!found && batch_busy(c, k, dv[c])) begin
          found = 1'b1; m_active[c] = 1'b1; m_idx[c] = k; m_done[c] = 0;
        end
      end
    end else begin
      complete = 1'b1;
      for (int b = 0; b < bs; b++)
        if (bit_of(dv[c], m_idx[c] * bs + b) && ((m_done[c] >> b) & 1) == 0
            && eop[c][b] == 1'b0)
          complete = 1'b0;
      if (complete) begin
        m_pbat[c]++;
        m_done[c] = 0;
        eslots = 6'(eop[c]) << (m_idx[c] * bs);
        found = 1'b0;
        for (int i = 1; i <= nb; i++) begin
          k = (m_idx[c] + i) % nb;
          v = (k == m_idx[c]) ? (dv[c] & ~eslots) : dv[c];
          if (!found && batch_busy(c, k, v)) begin
            found = 1'b1; m_idx[c] = k; m_sw[c] = 1'b1;
          end
        end
        if (!found) begin
          m_active[c] = 1'b0;
          m_idx[c] = (m_idx[c] + 1) % nb;
        end
      end else begin
        m_done[c] = m_done[c] | int'(eop[c]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      dv[c] = '0; eop[c] = '0; fired[c] = '0;
      m_active[c] = 1'b0; m_idx[c] = 0; m_done[c] = 0; m_sw[c] = 1'b0;
      m_pidle[c] = 0; m_pbat[c] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      checks++; if (o_valid[c] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", c, o_valid[c]); end
      checks++; if (o_idx[c] !== 32'd0) begin errors++; $display("FAIL reset_idx[%0d]: got %0d expected 0", c, o_idx[c]); end
      checks++; if (o_en[c] !== 32'd0) begin errors++; $display("FAIL reset_enable[%0d]: got %0h expected 0", c, o_en[c]); end
      checks++; if (o_sw[c] !== 1'b0) begin errors++; $display("FAIL reset_switch[%0d]: got %b expected 0", c, o_sw[c]); end
      checks++; if (o_pidle[c] !== 32'd0) begin errors++; $display("FAIL reset_pidle[%0d]: got %0d expected 0", c, o_pidle[c]); end
      checks++; if (o_pbat[c] !== 32'd0) begin errors++; $display("FAIL reset_pbat[%0d]: got %0d expected 0", c, o_pbat[c]); end
    end
  endtask

  task automatic test_idle_to_active();
    apply_reset();
    repeat (4) tick();
    dv[0] = 6'b000100;
    tick();
    checks++; if (i41.batch_valid !== 1'b1) begin errors++; $display("FAIL wake_valid: got %b expected 1", i41.batch_valid); end
    checks++; if (i41.batch_idx !== 2'd2) begin errors++; $display("FAIL wake_idx: got %0d expected 2", i41.batch_idx); end
    checks++; if (i41.block_enable !== 1'b1) begin errors++; $display("FAIL wake_enable: got %b expected 1", i41.block_enable); end
    checks++; if (i41.batch_switch !== 1'b0) begin errors++; $display("FAIL wake_switch: got %b expected 0", i41.batch_switch); end
    checks++; if (i41.perf_idle_cycles !== 32'd5) begin errors++; $display("FAIL wake_pidle: got %0d expected 5", i41.perf_idle_cycles); end
    eop[0] = 2'b01;
    tick();
    dv[0] = '0; eop[0] = '0;
    checks++; if (i41.batch_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", i41.batch_valid); end
    checks++; if (i41.batch_idx !== 2'd3) begin errors++; $display("FAIL drain_idx: got %0d expected 3", i41.batch_idx); end
    checks++; if (i41.perf_batches !== 32'd1) begin errors++; $display("FAIL drain_pbat: got %0d expected 1", i41.perf_batches); end
  endtask

  task automatic test_round_robin();
    int seq [4] = '{1, 2, 3, 0};
    apply_reset();
    dv[0] = 6'b001111;
    tick();
    checks++; if (i41.batch_idx !== 2'd0 || i41.batch_valid !== 1'b1) begin errors++; $display("FAIL rr_start: got idx=%0d valid=%b expected idx=0 valid=1", i41.batch_idx, i41.batch_valid); end
    eop[0] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (32'(i41.batch_idx) !== 32'(seq[i])) begin errors++; $display("FAIL rr_idx[%0d]: got %0d expected %0d", i, i41.batch_idx, seq[i]); end
      checks++; if (i41.batch_switch !== 1'b1) begin errors++; $display("FAIL rr_switch[%0d]: got %b expected 1", i, i41.batch_switch); end
    end
    checks++; if (i41.perf_batches !== 32'd4) begin errors++; $display("FAIL rr_pbat: got %0d expected 4", i41.perf_batches); end
    eop[0] = '0; dv[0] = '0;
  endtask

  task automatic test_partial_eop();
    apply_reset();
    dv[1] = 6'b001111;
    tick();
    checks++; if (i42.batch_idx !== 1'b0 || i42.block_enable !== 2'b11) begin errors++; $display("FAIL part_start: got idx=%0d en=%b expected idx=0 en=11", i42.batch_idx, i42.block_enable); end
    eop[1] = 2'b01;
    tick();
    eop[1] = 2'b00;
    checks++; if (i42.block_enable !== 2'b10) begin errors++; $display("FAIL part_en_n1: got %b expected 10", i42.block_enable); end
    for (int i = 2; i <= 3; i++) begin
      tick();
      checks++; if (i42.block_enable !== 2'b10 || i42.batch_idx !== 1'b0) begin errors++; $display("FAIL part_hold_n%0d: got idx=%0d en=%b expected idx=0 en=10", i, i42.batch_idx, i42.block_enable); end
    end
    eop[1] = 2'b10;
    tick();
    eop[1] = 2'b00;
    checks++; if (i42.batch_idx !== 1'b1) begin errors++; $display("FAIL part_switch_idx: got %0d expected 1", i42.batch_idx); end
    checks++; if (i42.batch_switch !== 1'b1) begin errors++; $display("FAIL part_switch_pulse: got %b expected 1", i42.batch_switch); end
    checks++; if (i42.block_enable !== 2'b11) begin errors++; $display("FAIL part_switch_en: got %b expected 11", i42.block_enable); end
    checks++; if (i42.perf_batches !== 32'd1) begin errors++; $display("FAIL part_pbat: got %0d expected 1", i42.perf_batches); end
    dv[1] = '0;
  endtask

  task automatic test_skip_empty();
    int seq [4] = '{3, 0, 3, 0};
    apply_reset();
    dv[0] = 6'b001001;
    tick();
    checks++; if (i41.batch_idx !== 2'd0) begin errors++; $display("FAIL skip_start: got %0d expected 0", i41.batch_idx); end
    eop[0] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (32'(i41.batch_idx) !== 32'(seq[i]) || i41.batch_valid !== 1'b1) begin errors++; $display("FAIL skip_idx[%0d]: got idx=%0d valid=%b expected idx=%0d valid=1", i, i41.batch_idx, i41.batch_valid, seq[i]); end
    end
    checks++; if (i41.perf_idle_cycles !== 32'd1) begin errors++; $display("FAIL skip_pidle: got %0d expected 1", i41.perf_idle_cycles); end
    eop[0] = '0; dv[0] = '0;
  endtask

  task automatic test_wrap();
    apply_reset();
    dv[2] = 6'b010000;
    tick();
    checks++; if (i62.batch_idx !== 2'd2 || i62.block_enable !== 2'b11) begin errors++; $display("FAIL wrap_start: got idx=%0d en=%b expected idx=2 en=11", i62.batch_idx, i62.block_enable); end
    dv[2] = 6'b010001;
    eop[2] = 2'b01;
    tick();
    dv[2] = 6'b000001; eop[2] = '0;
    checks++; if (i62.batch_idx !== 2'd0) begin errors++; $display("FAIL wrap_idx: got %0d expected 0", i62.batch_idx); end
    checks++; if (i62.batch_switch !== 1'b1 || i62.batch_valid !== 1'b1) begin errors++; $display("FAIL wrap_switch: got sw=%b valid=%b expected 1 1", i62.batch_switch, i62.batch_valid); end
    dv[2] = '0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    dv[1] = 6'b001100;
    tick();
    checks++; if (i42.batch_idx !== 1'b1) begin errors++; $display("FAIL arst_setup_idx: got %0d expected 1", i42.batch_idx); end
    eop[1] = 2'b01;
    tick();
    eop[1] = '0;
    checks++; if (i42.block_enable !== 2'b10) begin errors++; $display("FAIL arst_setup_en: got %b expected 10", i42.block_enable); end
    reset_n = 1'b0;
    #1;
    checks++; if (i42.batch_valid !== 1'b0 || i42.batch_idx !== 1'b0) begin errors++; $display("FAIL arst_state: got valid=%b idx=%0d expected 0 0", i42.batch_valid, i42.batch_idx); end
    checks++; if (i42.block_enable !== 2'b00 || i42.batch_switch !== 1'b0) begin errors++; $display("FAIL arst_outputs: got en=%b sw=%b expected 00 0", i42.block_enable, i42.batch_switch); end
    checks++; if (i42.perf_idle_cycles !== 32'd0 || i42.perf_batches !== 32'd0) begin errors++; $display("FAIL arst_perf: got idle=%0d bat=%0d expected 0 0", i42.perf_idle_cycles, i42.perf_batches); end
    @(negedge clk);
    reset_n = 1'b1;
    dv[1] = 6'b001111;
    tick();
    checks++; if (i42.batch_idx !== 1'b0 || i42.batch_valid !== 1'b1) begin errors++; $display("FAIL arst_restart: got idx=%0d valid=%b expected idx=0 valid=1", i42.batch_idx, i42.batch_valid); end
    dv[1] = '0;
  endtask

  task automatic test_random(input int cycles);
    int bs, s, exp_en;
    logic [5:0] nv;
    logic [1:0] e;
    apply_reset();
    for (int n = 0; n < cycles; n++) begin
      for (int c = 0; c < 3; c++) begin
        bs = c_bs[c];
        nv = dv[c];
        for (int i = 0; i < c_issue[c]; i++) begin
          if (bit_of(fired[c], i)) begin
            if ($urandom % 2 == 0) nv = nv & ~(6'd1 << i);
          end else if (!bit_of(nv, i) && $urandom % 5 == 0) begin
            nv = nv | (6'd1 << i);
          end
        end
        dv[c] = nv;
        e = '0;
        if (m_active[c]) begin
          for (int b = 0; b < bs; b++) begin
            s = m_idx[c] * bs + b;
            if (bit_of(nv, s) && ((m_done[c] >> b) & 1) == 0 && $urandom % 3 == 0)
              e = e | 2'(1 << b);
          end
        end
        eop[c] = e;
        fired[c] = m_active[c] ? (6'(e) << (m_idx[c] * bs)) : '0;
      end
      @(posedge clk);
      for (int c = 0; c < 3; c++) model_step(c);
      #1;
      for (int c = 0; c < 3; c++) begin
        exp_en = m_active[c] ? (~m_done[c] & ((1 << c_bs[c]) - 1)) : 0;
        checks++; if (o_valid[c] !== m_active[c]) begin errors++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b expected %b", c, n, o_valid[c], m_active[c]); end
        checks++; if (o_idx[c] !== 32'(m_idx[c])) begin errors++; $display("FAIL rnd_idx[%0d] cyc %0d: got %0d expected %0d", c, n, o_idx[c], m_idx[c]); end
        checks++; if (o_en[c] !== 32'(exp_en)) begin errors++; $display("FAIL rnd_enable[%0d] cyc %0d: got %0h expected %0h", c, n, o_en[c], exp_en); end
        checks++; if (o_sw[c] !== m_sw[c]) begin errors++; $display("FAIL rnd_switch[%0d] cyc %0d: got %b expected %b", c, n, o_sw[c], m_sw[c]); end
        checks++; if (o_pidle[c] !== m_pidle[c]) begin errors++; $display("FAIL rnd_pidle[%0d] cyc %0d: got %0d expected %0d", c, n, o_pidle[c], m_pidle[c]); end
        checks++; if (o_pbat[c] !== m_pbat[c]) begin errors++; $display("FAIL rnd_pbat[%0d] cyc %0d: got %0d expected %0d", c, n, o_pbat[c], m_pbat[c]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_to_active();
    test_round_robin();
    test_partial_eop();
    test_skip_empty();
    test_wrap();
    test_async_reset();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
